// File: rtl/code_pattern_decoder.sv
// code_pattern_decoder: FIFO-buffered 4-bit result code to 3-bit pattern decoder.
// Optional unknown-code counter enabled by defining CODE_DEC_ERRCNT_EN.
module code_pattern_decoder #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 10
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [3:0] i_Code,
    input  logic       i_Code_DV,
    output logic       o_Ready,
    output logic       o_VAL_1,
    output logic       o_VAL_2,
    output logic       o_VAL_3,
    output logic       o_Pattern_DV,
    output logic       o_Default,
    output logic       o_Error,
    output logic       o_Busy,
    output logic [7:0] o_Err_Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_HOLD
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [3:0]    mem [DEPTH];
    logic [3:0]    code_q;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_cnt_n;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          apply_ok;
    logic          apply_err;
    logic          code_known;
    logic [2:0]    pat_dec;
    logic          def_dec;

    // Extra wrap bit on the pointers distinguishes full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW])
                  && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push    = i_Code_DV && !full;
    assign o_Ready = !full;
    assign o_Busy  = (state != S_IDLE) || !empty;

    // Decode the popped code into its pattern and default flag.
    always_comb begin
        code_known = 1'b1;
        pat_dec    = 3'b000;
        def_dec    = 1'b0;
        unique case (code_q)
            4'd0:    pat_dec = 3'b000;
            4'd1:    pat_dec = 3'b001;
            4'd2:    pat_dec = 3'b010;
            4'd9: begin
                pat_dec = 3'b111;
                def_dec = 1'b1;
            end
            default: code_known = 1'b0;
        endcase
    end

    // Next-state logic: pop in IDLE, decode in APPLY, count down in HOLD.
    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        pop        = 1'b0;
        apply_ok   = 1'b0;
        apply_err  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = S_APPLY;
                end
            end
            S_APPLY: begin
                if (code_known) begin
                    apply_ok   = 1'b1;
                    hold_cnt_n = HOLD_LOAD;
                    state_n    = S_HOLD;
                end else begin
                    apply_err = 1'b1;
                    state_n   = S_IDLE;
                end
            end
            S_HOLD: begin
                if (hold_cnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    hold_cnt_n = hold_cnt - 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // FSM state and hold counter registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_cnt_n;
        end
    end

    // FIFO pointers; a full FIFO drops incoming codes rather than stalling.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage needs no reset; the pointers define valid contents.
    always_ff @(posedge i_Clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= i_Code;
    end

    // Capture the head entry on pop for decoding in APPLY.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            code_q <= '0;
        end else if (pop) begin
            code_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    // Registered outputs; the pattern persists until the next valid code.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            {o_VAL_1, o_VAL_2, o_VAL_3} <= 3'b000;
            o_Default    <= 1'b0;
            o_Pattern_DV <= 1'b0;
            o_Error      <= 1'b0;
        end else begin
            o_Pattern_DV <= apply_ok;
            o_Error      <= apply_err;
            if (apply_ok) begin
                {o_VAL_1, o_VAL_2, o_VAL_3} <= pat_dec;
                o_Default <= def_dec;
            end
        end
    end

`ifdef CODE_DEC_ERRCNT_EN
    logic [7:0] err_cnt;

    // Saturating count of unknown codes; cleared only by reset.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            err_cnt <= '0;
        end else if (apply_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign o_Err_Count = err_cnt;
`else
    assign o_Err_Count = '0;
`endif

endmodule

// File: tb/tb_code_pattern_decoder.sv
// tb_code_pattern_decoder: directed bench with a scoreboard of accepted codes.
// Covers reset, latency, burst spacing, unknown codes, full FIFO, mid-HOLD reset.
module tb_code_pattern_decoder;

    localparam int DEPTH = 4;
    localparam int HOLD  = 10;

    logic       i_Clk     = 1'b0;
    logic       i_Rst_L   = 1'b0;
    logic [3:0] i_Code    = 4'd0;
    logic       i_Code_DV = 1'b0;
    logic       o_Ready;
    logic       o_VAL_1;
    logic       o_VAL_2;
    logic       o_VAL_3;
    logic       o_Pattern_DV;
    logic       o_Default;
    logic       o_Error;
    logic       o_Busy;
    logic [7:0] o_Err_Count;

    int         n_vec  = 0;
    int         n_bad  = 0;
    int         cyc    = 0;
    int         n_acc  = 0;
    int         n_errp = 0;
    logic [3:0] sb[$];
    int         dv_times[$];
    logic [2:0] exp_pat = 3'b000;
    logic       exp_def = 1'b0;
    logic [3:0] mon_code;

    code_pattern_decoder #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_Code       (i_Code),
        .i_Code_DV    (i_Code_DV),
        .o_Ready      (o_Ready),
        .o_VAL_1      (o_VAL_1),
        .o_VAL_2      (o_VAL_2),
        .o_VAL_3      (o_VAL_3),
        .o_Pattern_DV (o_Pattern_DV),
        .o_Default    (o_Default),
        .o_Error      (o_Error),
        .o_Busy       (o_Busy),
        .o_Err_Count  (o_Err_Count)
    );

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) cyc++;

    function automatic logic [2:0] map_pat(input logic [3:0] c);
        case (c)
            4'd1:    return 3'b001;
            4'd2:    return 3'b010;
            4'd9:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic is_known(input logic [3:0] c);
        return (c == 4'd0) || (c == 4'd1) || (c == 4'd2) || (c == 4'd9);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] c);
        logic acc;
        @(negedge i_Clk);
        i_Code    = c;
        i_Code_DV = 1'b1;
        acc       = o_Ready;
        @(posedge i_Clk);
        if (acc) begin
            sb.push_back(c);
            n_acc++;
        end
        #1 i_Code_DV = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge i_Clk);
            if (!o_Busy && sb.size() == 0) break;
        end
        check({tag, "_busy"}, o_Busy, 0);
        check({tag, "_sb"}, sb.size(), 0);
    endtask

    // Scoreboard: every pattern or error pulse consumes one accepted code.
    always @(negedge i_Clk) begin
        if (i_Rst_L && (o_Pattern_DV || o_Error)) begin
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                mon_code = sb.pop_front();
                check("pulse_kind", {o_Pattern_DV, o_Error},
                      is_known(mon_code) ? 2'b10 : 2'b01);
                if (is_known(mon_code)) begin
                    exp_pat = map_pat(mon_code);
                    exp_def = (mon_code == 4'd9);
                end else begin
                    n_errp++;
                end
                check("pattern", {o_VAL_1, o_VAL_2, o_VAL_3}, exp_pat);
                check("default", o_Default, exp_def);
                if (o_Pattern_DV) dv_times.push_back(cyc);
            end
        end
    end

    initial begin
        int d1;
        int d2;
        int e0;
        logic [3:0] fill[6];
        int exp_cnt;

        // Reset state
        repeat (3) @(negedge i_Clk);
        check("rst_val", {o_VAL_1, o_VAL_2, o_VAL_3}, 3'b000);
        check("rst_dv", o_Pattern_DV, 0);
        check("rst_def", o_Default, 0);
        check("rst_err", o_Error, 0);
        check("rst_cnt", o_Err_Count, 0);
        check("rst_busy", o_Busy, 0);
        check("rst_ready", o_Ready, 1);
        i_Rst_L = 1'b1;
        repeat (2) @(negedge i_Clk);

        // Single code latency and hold length
        push(4'd1);
        @(negedge i_Clk);
        @(negedge i_Clk);
        check("lat_n1_dv", o_Pattern_DV, 0);
        @(negedge i_Clk);
        check("lat_n2_dv", o_Pattern_DV, 1);
        check("lat_n2_val", {o_VAL_1, o_VAL_2, o_VAL_3}, 3'b001);
        repeat (9) @(negedge i_Clk);
        check("hold_busy_hi", o_Busy, 1);
        @(negedge i_Clk);
        check("hold_busy_lo", o_Busy, 0);

        // Burst of valid codes, spacing HOLD+2
        dv_times.delete();
        push(4'd0);
        push(4'd2);
        push(4'd9);
        wait_idle(60, "burst");
        check("burst_cnt", dv_times.size(), 3);
        d1 = (dv_times.size() >= 2) ? dv_times[1] - dv_times[0] : -1;
        d2 = (dv_times.size() >= 3) ? dv_times[2] - dv_times[1] : -1;
        check("burst_gap1", d1, HOLD + 2);
        check("burst_gap2", d2, HOLD + 2);
        check("burst_def", o_Default, 1);

        // Unknown code followed by a valid one
        e0 = n_errp;
        push(4'd5);
        push(4'd2);
        wait_idle(40, "unknown");
        check("unk_pulses", n_errp - e0, 1);
        check("unk_val", {o_VAL_1, o_VAL_2, o_VAL_3}, 3'b010);
        check("unk_def", o_Default, 0);
`ifdef CODE_DEC_ERRCNT_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif
        check("unk_errcnt", o_Err_Count, exp_cnt);

        // Full FIFO while holding: 4 accepted, 2 dropped
        push(4'd0);
        repeat (3) @(negedge i_Clk);
        n_acc = 0;
        fill = '{4'd1, 4'd2, 4'd9, 4'd0, 4'd1, 4'd2};
        for (int i = 0; i < 6; i++) begin
            if (i >= DEPTH) check("full_ready", o_Ready, 0);
            push(fill[i]);
        end
        check("full_acc", n_acc, DEPTH);
        wait_idle(100, "full");

        // Reset mid-HOLD with 3 codes queued
        push(4'd1);
        push(4'd2);
        push(4'd9);
        push(4'd0);
        repeat (3) @(negedge i_Clk);
        check("mid_busy", o_Busy, 1);
        #2;
        sb.delete();
        exp_pat = 3'b000;
        exp_def = 1'b0;
        dv_times.delete();
        i_Rst_L = 1'b0;
        #1;
        check("mid_val", {o_VAL_1, o_VAL_2, o_VAL_3}, 3'b000);
        check("mid_dv", o_Pattern_DV, 0);
        check("mid_def", o_Default, 0);
        check("mid_busy_lo", o_Busy, 0);
        check("mid_ready", o_Ready, 1);
        check("mid_cnt", o_Err_Count, 0);
        repeat (2) @(negedge i_Clk);
        i_Rst_L = 1'b1;
        repeat (40) @(negedge i_Clk);
        check("post_dv_cnt", dv_times.size(), 0);
        check("post_busy", o_Busy, 0);
        check("post_val", {o_VAL_1, o_VAL_2, o_VAL_3}, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
